// File: rtl/player2_link_rx.sv
// Receive side of the two-board link: synchronises the remote pause/reload/score pins,
// debounces each line, qualifies the score as a whole word and flags illegal score steps.
module player2_link_rx #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 65000,
    parameter int SCORE_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               player2_pause_raw,
    input  logic               player2_reload_raw,
    input  logic [SCORE_W-1:0] player2_score_raw,
    output logic               player2_pause,
    output logic               player2_reload,
    output logic               player2_reload_pulse,
    output logic [SCORE_W-1:0] player2_score,
    output logic               score_update,
    output logic               score_step_err
);

    localparam int IW = SCORE_W + 2;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [IW-1:0]      raw_w;
    logic [IW-1:0]      sync_q [SYNC_STAGES];
    logic [IW-1:0]      synced_w;
    logic [SCORE_W-1:0] syn_score_w;
    logic [1:0]         deb_w;

    // Pure wiring into the first flop: bit0 = pause, bit1 = reload, upper bits = score.
    assign raw_w       = {player2_score_raw, player2_reload_raw, player2_pause_raw};
    assign synced_w    = sync_q[SYNC_STAGES-1];
    assign syn_score_w = synced_w[IW-1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= raw_w;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bit
        logic          lvl_q, lvl_d;
        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            lvl_d = lvl_q;
            cnt_d = '0;
            if (synced_w[gi] != lvl_q) begin
                if (cnt_q == CW'(STABLE_CYCLES - 1)) lvl_d = synced_w[gi];
                else                                 cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lvl_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                lvl_q <= lvl_d;
                cnt_q <= cnt_d;
            end
        end

        assign deb_w[gi] = lvl_q;
    end

    logic [SCORE_W-1:0] cand_q, cand_d, score_q, score_d;
    logic [CW-1:0]      scnt_q, scnt_d;
    logic               upd_q, upd_d, err_q, err_d;
    logic               reload_prev_q, pulse_q, pulse_d;

    // Loading cand counts as the first qualified sample, so a word commits after
    // STABLE_CYCLES identical synced samples, matching the bit-line latency.
    always_comb begin
        cand_d  = cand_q;
        scnt_d  = scnt_q;
        score_d = score_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        if (syn_score_w != cand_q) begin
            cand_d = syn_score_w;
            scnt_d = '0;
        end else if (cand_q != score_q) begin
            if (scnt_q == CW'(STABLE_CYCLES - 2)) begin
                score_d = cand_q;
                scnt_d  = '0;
                upd_d   = 1'b1;
                err_d   = (cand_q != SCORE_W'(score_q + SCORE_W'(1))) && (cand_q != '0);
            end else begin
                scnt_d = scnt_q + CW'(1);
            end
        end else begin
            scnt_d = '0;
        end
    end

    assign pulse_d = deb_w[1] & ~reload_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q        <= '0;
            scnt_q        <= '0;
            score_q       <= '0;
            upd_q         <= 1'b0;
            err_q         <= 1'b0;
            reload_prev_q <= 1'b0;
            pulse_q       <= 1'b0;
        end else begin
            cand_q        <= cand_d;
            scnt_q        <= scnt_d;
            score_q       <= score_d;
            upd_q         <= upd_d;
            err_q         <= err_d;
            reload_prev_q <= deb_w[1];
            pulse_q       <= pulse_d;
        end
    end

    assign player2_pause        = deb_w[0];
    assign player2_reload       = deb_w[1];
    assign player2_reload_pulse = pulse_q;
    assign player2_score        = score_q;
    assign score_update         = upd_q;
    assign score_step_err       = err_q;

endmodule

// File: tb/tb_player2_link_rx.sv
// Bench for player2_link_rx with SYNC_STAGES=2, STABLE_CYCLES=4 (latency 6 edges),
// compared each cycle against a sample-window reference model plus scenario checks.
module tb_player2_link_rx;

    localparam int S  = 2;
    localparam int ST = 4;
    localparam int D  = S + ST;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p_raw = 1'b0;
    logic       r_raw = 1'b0;
    logic [3:0] s_raw = 4'd0;

    logic       player2_pause, player2_reload, player2_reload_pulse;
    logic [3:0] player2_score;
    logic       score_update, score_step_err;

    int n_checks = 0;
    int n_fail   = 0;

    player2_link_rx #(.SYNC_STAGES(S), .STABLE_CYCLES(ST), .SCORE_W(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .player2_pause_raw    (p_raw),
        .player2_reload_raw   (r_raw),
        .player2_score_raw    (s_raw),
        .player2_pause        (player2_pause),
        .player2_reload       (player2_reload),
        .player2_reload_pulse (player2_reload_pulse),
        .player2_score        (player2_score),
        .score_update         (score_update),
        .score_step_err       (score_step_err)
    );

    always #5 clk = ~clk;

    // Reference model: last D raw samples (index 0 = newest) and the expected outputs.
    logic       hp [D];
    logic       hr [D];
    logic [3:0] hs [D];
    logic       m_pause, m_reload, m_reload_old, m_pulse, m_upd, m_err;
    logic [3:0] m_score;

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            hp[i] = 1'b0; hr[i] = 1'b0; hs[i] = 4'd0;
        end
        m_pause = 0; m_reload = 0; m_reload_old = 0; m_pulse = 0;
        m_upd = 0; m_err = 0; m_score = 4'd0;
    endtask

    // Advance one clock: a line takes a new value once the STABLE samples that have
    // left the synchroniser all agree on it.
    task automatic tick();
        logic flip_p, flip_r, same;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            for (int i = D - 1; i > 0; i--) begin
                hp[i] = hp[i-1]; hr[i] = hr[i-1]; hs[i] = hs[i-1];
            end
            hp[0] = p_raw; hr[0] = r_raw; hs[0] = s_raw;
            m_pulse      = m_reload & ~m_reload_old;
            m_reload_old = m_reload;
            flip_p = 1'b1; flip_r = 1'b1; same = 1'b1;
            for (int j = S; j < D; j++) begin
                if (hp[j] == m_pause)  flip_p = 1'b0;
                if (hr[j] == m_reload) flip_r = 1'b0;
                if (hs[j] != hs[S])    same   = 1'b0;
            end
            if (flip_p) m_pause  = ~m_pause;
            if (flip_r) m_reload = ~m_reload;
            m_upd = same && (hs[S] != m_score);
            m_err = m_upd && (hs[S] != 4'(m_score + 4'd1)) && (hs[S] != 4'd0);
            if (m_upd) m_score = hs[S];
        end
        #1;
    endtask

    function automatic logic [8:0] dut_vec();
        return {player2_pause, player2_reload, player2_reload_pulse, player2_score,
                score_update, score_step_err};
    endfunction

    function automatic logic [8:0] model_vec();
        return {m_pause, m_reload, m_pulse, m_score, m_upd, m_err};
    endfunction

    task automatic test_reset();
        model_clear();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (dut_vec() !== 9'd0) begin
            n_fail++; $display("FAIL reset_hold: got %b expected %b", dut_vec(), 9'd0);
        end
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_checks++;
            if (dut_vec() !== 9'd0) begin
                n_fail++; $display("FAIL reset_idle cyc %0d: got %b expected %b", c, dut_vec(), 9'd0);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_reload();
        int rise_e = 0, pulse_e = 0, pulses = 0, fall_e = 0;
        r_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL reload_rise e%0d: got %b expected %b", e, dut_vec(), model_vec());
            end
            if (player2_reload && rise_e == 0) rise_e = e;
            if (player2_reload_pulse) begin pulses++; pulse_e = e; end
        end
        n_checks++;
        if (rise_e != 6 || pulses != 1 || pulse_e != 7) begin
            n_fail++; $display("FAIL reload_timing: got rise %0d pulses %0d at %0d expected rise 6 pulses 1 at 7",
                               rise_e, pulses, pulse_e);
        end
        r_raw = 1'b0; pulses = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL reload_fall e%0d: got %b expected %b", e, dut_vec(), model_vec());
            end
            if (!player2_reload && fall_e == 0) fall_e = e;
            if (player2_reload_pulse) pulses++;
        end
        n_checks++;
        if (fall_e != 6 || pulses != 0) begin
            n_fail++; $display("FAIL reload_fall_timing: got fall %0d pulses %0d expected fall 6 pulses 0", fall_e, pulses);
        end
        $display("test_reload done: rise %0d pulse %0d fall %0d", rise_e, pulse_e, fall_e);
    endtask

    task automatic test_pause();
        int highs = 0, rise_e = 0, fall_e = 0;
        for (int e = 1; e <= 15; e++) begin
            p_raw = (e <= 3);
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL pause_short e%0d: got %b expected %b", e, dut_vec(), model_vec());
            end
            if (player2_pause) highs++;
        end
        n_checks++;
        if (highs != 0) begin
            n_fail++; $display("FAIL pause_glitch: got %0d high cycles expected 0", highs);
        end
        for (int e = 1; e <= 22; e++) begin
            p_raw = (e <= 10);
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL pause_long e%0d: got %b expected %b", e, dut_vec(), model_vec());
            end
            if (player2_pause && rise_e == 0) rise_e = e;
            if (rise_e != 0 && !player2_pause && fall_e == 0) fall_e = e;
        end
        n_checks++;
        if (rise_e != 6 || fall_e != 16) begin
            n_fail++; $display("FAIL pause_timing: got rise %0d fall %0d expected rise 6 fall 16", rise_e, fall_e);
        end
        $display("test_pause done: rise %0d fall %0d", rise_e, fall_e);
    endtask

    task automatic test_score_step();
        int upds = 0, errs = 0;
        s_raw = 4'd1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL score_0to1 e%0d: got %b expected %b", e, dut_vec(), model_vec());
            end
            upds += int'(score_update); errs += int'(score_step_err);
        end
        n_checks++;
        if (upds != 1 || errs != 0 || player2_score !== 4'd1) begin
            n_fail++; $display("FAIL score_0to1_sum: got upd %0d err %0d score %0d expected 1 0 1",
                               upds, errs, player2_score);
        end
        upds = 0; errs = 0;
        for (int e = 1; e <= 12; e++) begin
            s_raw = (e <= 2) ? 4'd2 : 4'd3;
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL score_skew e%0d: got %b expected %b", e, dut_vec(), model_vec());
            end
            upds += int'(score_update); errs += int'(score_step_err);
        end
        n_checks++;
        if (upds != 1 || errs != 1 || player2_score !== 4'd3) begin
            n_fail++; $display("FAIL score_skew_sum: got upd %0d err %0d score %0d expected 1 1 3",
                               upds, errs, player2_score);
        end
        $display("test_score_step done: score %0d", player2_score);
    endtask

    task automatic test_score_wrap();
        int upds = 0, errs = 0;
        logic [3:0] seq [4];
        seq[0] = 4'd13; seq[1] = 4'd14; seq[2] = 4'd15; seq[3] = 4'd0;
        for (int k = 0; k < 4; k++) begin
            s_raw = seq[k];
            for (int e = 1; e <= 10; e++) begin
                tick();
                n_checks++;
                if (dut_vec() !== model_vec()) begin
                    n_fail++; $display("FAIL score_wrap v%0d e%0d: got %b expected %b", seq[k], e, dut_vec(), model_vec());
                end
                if (k > 0) begin upds += int'(score_update); errs += int'(score_step_err); end
            end
        end
        n_checks++;
        if (upds != 3 || errs != 0) begin
            n_fail++; $display("FAIL score_wrap_sum: got upd %0d err %0d expected 3 0", upds, errs);
        end
        $display("test_score_wrap done: %0d updates", upds);
    endtask

    task automatic test_reset_mid();
        int commit_e = 0;
        s_raw = 4'd5;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== 9'd0) begin
            n_fail++; $display("FAIL reset_async: got %b expected %b", dut_vec(), 9'd0);
        end
        repeat (2) tick();
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL reset_mid e%0d: got %b expected %b", e, dut_vec(), model_vec());
            end
            if (player2_score == 4'd5 && commit_e == 0) begin
                commit_e = e;
                n_checks++;
                if (!score_update || !score_step_err) begin
                    n_fail++; $display("FAIL reset_mid_commit: got upd %b err %b expected 1 1", score_update, score_step_err);
                end
            end
        end
        n_checks++;
        if (commit_e != 6) begin
            n_fail++; $display("FAIL reset_mid_latency: got edge %0d expected 6", commit_e);
        end
        $display("test_reset_mid done: commit at edge %0d", commit_e);
    endtask

    task automatic test_random();
        int hold_p = 0, hold_r = 0, hold_s = 0, upds = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold_p == 0) begin p_raw = 1'($urandom); hold_p = $urandom_range(1, 9); end
            if (hold_r == 0) begin r_raw = 1'($urandom); hold_r = $urandom_range(1, 9); end
            if (hold_s == 0) begin s_raw = 4'($urandom); hold_s = $urandom_range(1, 9); end
            hold_p--; hold_r--; hold_s--;
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL random cyc %0d: got %b expected %b", c, dut_vec(), model_vec());
            end
            upds += int'(score_update);
        end
        $display("test_random done: %0d score updates", upds);
    endtask

    initial begin
        test_reset();
        test_reload();
        test_pause();
        test_score_step();
        test_score_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
